cdda_capture: RTL
=================

# cdda_capture

I2S receiver for CD-DA audio: the inverse of the CDDA transmitter. It deserializes an external Philips-I2S stream (bck/sd/lrck, 16-bit stereo) into a 128-frame ring buffer. The AVR reads that buffer through the shared sram bus window. It sits beside the other sram-bus peripherals, is decoded by the top-level chip-select, and raises an optional fill-level interrupt to the CPU.

## Interface
Parameters:
- ADDR_BITS, 10: width of the sram_a slice decoded inside the window.
- IRQ_LEVEL, 64: fill level in frames, 1..128, at or above which irq asserts.

Ports:
- clk  in  1  system clock; must be at least 6× bck frequency.
- nrst  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- bck  in  1  I2S bit clock, asynchronous.
- sd  in  1  I2S serial data, asynchronous.
- lrck  in  1  word select: low = left, high = right; asynchronous.
- sram_a  in  ADDR_BITS  byte address within the window.
- sram_d_in  in  8  CPU write data.
- sram_d_out  out  8  CPU read data.
- sram_cs  in  1  window select.
- sram_oe  in  1  read strobe.
- sram_we  in  1  write strobe.
- sram_wait  out  1  stall request to the CPU.
- irq  out  1  level interrupt.

## Operation
- bck, sd and lrck each pass through a 2-flop synchronizer. Rising-bck detect = synced bck now 1, previous 0.
- Framing: a word starts 1 bck after an lrck transition. 16 bits are shifted in MSB-first on rising bck. Bits 17 and later are ignored.
- If lrck toggles before a word has 16 bits, the word is short: set sticky ERR and discard the whole frame.
- Aligner states:
  - IDLE: CTRL.EN = 0.
  - SYNC: waiting for an lrck falling edge.
  - LEFT, RIGHT: shifting the respective word.
  - Transitions: EN 0→1 goes IDLE→SYNC. An lrck fall in SYNC goes to LEFT. An lrck rise in LEFT goes to RIGHT. An lrck fall in RIGHT goes to LEFT. EN = 0 from any state goes to IDLE, and any partial frame is dropped.
- Commit: on the 16th right bit, write the {R,L} frame to buffer index wptr[6:0] and increment wptr.
- Buffer layout: bytes 4n..4n+3 = L[7:0], L[15:8], R[7:0], R[15:8].
- Pointers: wptr and rptr are 8-bit, mod 256. LEVEL = wptr − rptr, range 0..128.
- When LEVEL = 128, a commit is dropped and sticky OVF is set. wptr does not move.
- Address map:
  - 0x000–0x1FF: buffer, read-only. Writes are ignored.
  - 0x200 CTRL, R/W: bit0 EN; bit1 FLUSH, write-1, reads 0.
  - 0x201 STATUS, RO: bit0 OVF, bit1 ERR, bit2 irq.
  - 0x202 WPTR, RO.
  - 0x203 RPTR, R/W.
  - 0x204 LEVEL, RO.
  - Other addresses read 0x00.
- RPTR write is accepted only if (wptr − new) mod 256 ≤ 128. Otherwise the write is ignored.
- FLUSH sets rptr = wptr and clears OVF and ERR. It does not change EN.
- irq = (LEVEL ≥ IRQ_LEVEL) & EN.

## Timing
- Reset values: sram_d_out = 0x00, sram_wait = 0, irq = 0. EN, OVF, ERR = 0; wptr = rptr = 0; aligner in IDLE.
- Pin-to-sample latency: 3 clk (2 sync + 1 edge detect).
- Commit: buffer write, wptr and LEVEL update 1 clk after the detected 16th right-bit edge. irq updates the following clk.
- Buffer reads use registered RAM:
  - sram_wait = 1 in the first clk of sram_cs & sram_oe to 0x000–0x1FF.
  - sram_d_out is valid, and sram_wait = 0, in the second clk.
- Register reads have zero wait states; sram_d_out is combinational from the address.
- Writes take effect on the clk where sram_cs & sram_we = 1. They have zero wait states.
- Commit and RPTR write in the same clk: both apply. LEVEL = new wptr − new rptr, and the RPTR range check uses the pre-commit wptr.
- Commit and FLUSH in the same clk: the commit applies first, then rptr = new wptr, so LEVEL = 0.
- Commit and a buffer read of the same index in the same clk: the read returns the old data.
- nrst asserted mid-frame: immediate return to reset values. The buffer contents are undefined.

## Configuration
- CDDA_CAPTURE_IRQ_EN:
  - Defined: irq logic and STATUS bit2 are as above.
  - Undefined: irq is tied to 0, STATUS bit2 reads 0, and IRQ_LEVEL is unused.

## Test plan
- Reset, enable, then 3 I2S frames L = 0x1234/R = 0xABCD, L = 0x0001/R = 0x8000, L = 0xFFFF/R = 0x0000 at bck = clk/8 → WPTR = 3, LEVEL = 3, bytes 0..3 = 34 12 CD AB, bytes 8..11 = FF FF 00 00, each buffer read shows 1 wait clk.
- Enable mid-right-word → first frame ignored until the lrck falling edge; the next complete frame lands at index 0.
- 129 frames with no reads → LEVEL = 128, OVF = 1, WPTR = 128. The data of frame 128 is absent. Writing RPTR = 0x10 gives LEVEL = 112. FLUSH gives LEVEL = 0, OVF = 0.
- lrck toggles after 10 bits of the left word → ERR = 1, no commit, WPTR unchanged. Following full frames commit normally.
- IRQ_LEVEL = 64: 63 frames → irq = 0; 64th frame → irq = 1 two clk after its commit edge. RPTR = 1 → irq = 0. Write RPTR = 0x90 while WPTR = 0x40 → ignored, RPTR unchanged.
- Assert nrst during a right word → all outputs and registers at reset values next clk; after release and re-enable, capture resumes from index 0.

Source files
------------

// File: rtl/cdda_capture.sv
// I2S (Philips, 16-bit stereo) receiver that fills a 128-frame ring buffer readable over the sram bus window.
// Optional fill-level interrupt is built when CDDA_CAPTURE_IRQ_EN is defined; otherwise irq is tied low.
module cdda_capture #(
    parameter int ADDR_BITS = 10,
    parameter int IRQ_LEVEL = 64
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 bck,
    input  logic                 sd,
    input  logic                 lrck,
    input  logic [ADDR_BITS-1:0] sram_a,
    input  logic [7:0]           sram_d_in,
    output logic [7:0]           sram_d_out,
    input  logic                 sram_cs,
    input  logic                 sram_oe,
    input  logic                 sram_we,
    output logic                 sram_wait,
    output logic                 irq
);

    localparam logic [ADDR_BITS-1:0] A_BUF_END = ADDR_BITS'('h200);
    localparam logic [ADDR_BITS-1:0] A_CTRL    = ADDR_BITS'('h200);
    localparam logic [ADDR_BITS-1:0] A_STATUS  = ADDR_BITS'('h201);
    localparam logic [ADDR_BITS-1:0] A_WPTR    = ADDR_BITS'('h202);
    localparam logic [ADDR_BITS-1:0] A_RPTR    = ADDR_BITS'('h203);
    localparam logic [ADDR_BITS-1:0] A_LEVEL   = ADDR_BITS'('h204);

    if (IRQ_LEVEL < 1 || IRQ_LEVEL > 128) begin : g_irq_level_check
        $error("cdda_capture: IRQ_LEVEL must be in 1..128");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

    logic        bck_s1_q, bck_s2_q, bck_d1_q;
    logic        sd_s1_q, sd_s2_q, lrck_s1_q, lrck_s2_q;
    state_t      state_q, state_d;
    logic        lr_prev_q, lr_prev_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] sh_q, sh_d, left_q, left_d;
    logic [31:0] frame_q, frame_d;
    logic        commit_q, commit_d;
    logic        en_q, en_d, ovf_q, ovf_d, err_q, err_d;
    logic [7:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic        rd_pend_q, rd_pend_d;
    logic [1:0]  bsel_q, bsel_d;
    logic [31:0] rd_word_q;
    logic [31:0] buf_mem [128];

    logic        bck_rise, lr_chg, bit_ok, err_set, flush, mem_we, buf_sel, irq_w;
    logic [15:0] sh_n;
    logic [4:0]  cnt_n;
    logic [7:0]  level;

`ifdef CDDA_CAPTURE_IRQ_EN
    localparam logic [7:0] IRQ_THR = 8'(IRQ_LEVEL);
    logic irq_q, irq_d;
    assign irq_w = irq_q;
`else
    assign irq_w = 1'b0;
`endif
    assign irq = irq_w;

    always_comb begin
        state_d   = state_q;
        lr_prev_d = lr_prev_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        left_d    = left_q;
        frame_d   = frame_q;
        commit_d  = 1'b0;
        err_set   = 1'b0;
        bck_rise  = bck_s2_q & ~bck_d1_q;
        lr_chg    = lrck_s2_q ^ lr_prev_q;
        bit_ok    = cnt_q < 5'd16;
        sh_n      = bit_ok ? {sh_q[14:0], sd_s2_q} : sh_q;
        cnt_n     = bit_ok ? cnt_q + 5'd1 : cnt_q;

        // The bit on the edge that reveals an lrck change still belongs to the old word.
        if (bck_rise) begin
            lr_prev_d = lrck_s2_q;
            case (state_q)
                ST_SYNC: begin
                    if (lr_chg && !lrck_s2_q) begin
                        state_d = ST_LEFT;
                        cnt_d   = '0;
                    end
                end
                ST_LEFT: begin
                    sh_d  = sh_n;
                    cnt_d = cnt_n;
                    if (lr_chg) begin
                        cnt_d = '0;
                        if (cnt_n != 5'd16) begin
                            err_set = 1'b1;
                            state_d = ST_SYNC;
                        end else begin
                            left_d  = sh_n;
                            state_d = ST_RIGHT;
                        end
                    end
                end
                ST_RIGHT: begin
                    sh_d  = sh_n;
                    cnt_d = cnt_n;
                    if (bit_ok && cnt_q == 5'd15) begin
                        commit_d = 1'b1;
                        frame_d  = {sh_n, left_q};
                    end
                    if (lr_chg) begin
                        cnt_d   = '0;
                        state_d = ST_LEFT;
                        if (cnt_n != 5'd16) err_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (!en_q)                  state_d = ST_IDLE;
        else if (state_q == ST_IDLE) state_d = ST_SYNC;

        en_d    = en_q;
        ovf_d   = ovf_q;
        err_d   = err_q | err_set;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        flush   = 1'b0;
        mem_we  = 1'b0;
        level   = wptr_q - rptr_q;
        if (sram_cs && sram_we) begin
            if (sram_a == A_CTRL) begin
                en_d  = sram_d_in[0];
                flush = sram_d_in[1];
            end
            if (sram_a == A_RPTR && (wptr_q - sram_d_in) <= 8'd128) rptr_d = sram_d_in;
        end
        if (commit_q) begin
            if (level == 8'd128) begin
                ovf_d = 1'b1;
            end else begin
                mem_we = 1'b1;
                wptr_d = wptr_q + 8'd1;
            end
        end
        // Flush follows the commit so a same-cycle frame is discarded as well.
        if (flush) begin
            rptr_d = wptr_d;
            ovf_d  = 1'b0;
            err_d  = 1'b0;
        end
`ifdef CDDA_CAPTURE_IRQ_EN
        irq_d = (level >= IRQ_THR) & en_q;
`endif

        buf_sel   = sram_a < A_BUF_END;
        sram_wait = sram_cs & sram_oe & buf_sel & ~rd_pend_q;
        rd_pend_d = sram_wait;
        bsel_d    = sram_wait ? sram_a[1:0] : bsel_q;
        sram_d_out = '0;
        if (sram_cs && sram_oe) begin
            if (buf_sel) begin
                if (rd_pend_q) begin
                    case (bsel_q)
                        2'd0:    sram_d_out = rd_word_q[7:0];
                        2'd1:    sram_d_out = rd_word_q[15:8];
                        2'd2:    sram_d_out = rd_word_q[23:16];
                        default: sram_d_out = rd_word_q[31:24];
                    endcase
                end
            end else begin
                case (sram_a)
                    A_CTRL:   sram_d_out = {7'd0, en_q};
                    A_STATUS: sram_d_out = {5'd0, irq_w, err_q, ovf_q};
                    A_WPTR:   sram_d_out = wptr_q;
                    A_RPTR:   sram_d_out = rptr_q;
                    A_LEVEL:  sram_d_out = level;
                    default:  sram_d_out = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            {bck_s1_q, bck_s2_q, bck_d1_q} <= '0;
            {sd_s1_q, sd_s2_q, lrck_s1_q, lrck_s2_q} <= '0;
            state_q   <= ST_IDLE;
            lr_prev_q <= 1'b0;
            cnt_q     <= '0;
            sh_q      <= '0;
            left_q    <= '0;
            frame_q   <= '0;
            commit_q  <= 1'b0;
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_pend_q <= 1'b0;
            bsel_q    <= '0;
`ifdef CDDA_CAPTURE_IRQ_EN
            irq_q     <= 1'b0;
`endif
        end else begin
            bck_s1_q  <= bck;
            bck_s2_q  <= bck_s1_q;
            bck_d1_q  <= bck_s2_q;
            sd_s1_q   <= sd;
            sd_s2_q   <= sd_s1_q;
            lrck_s1_q <= lrck;
            lrck_s2_q <= lrck_s1_q;
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            left_q    <= left_d;
            frame_q   <= frame_d;
            commit_q  <= commit_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_pend_q <= rd_pend_d;
            bsel_q    <= bsel_d;
`ifdef CDDA_CAPTURE_IRQ_EN
            irq_q     <= irq_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) buf_mem[wptr_q[6:0]] <= frame_q;
        if (sram_wait) rd_word_q <= buf_mem[sram_a[8:2]];
    end

endmodule
